// File: rtl/uart_tx_fifo_feeder_if.sv
// Handshake bundle between a byte producer / UART transmitter pair and the
// FIFO feeder. The feeder connects to the slave modport. The producer side,
// which also models the transmitter status, connects to the master modport.
interface uart_tx_fifo_feeder_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                i_Wr_DV;
    logic [7:0]          i_Wr_Byte;
    logic                i_Flush;
    logic                o_Full;
    logic                o_Empty;
    logic [DEPTH_LOG2:0] o_Count;
    logic                o_Overflow;
    logic                o_Tx_DV;
    logic [7:0]          o_Tx_Byte;
    logic                i_Tx_Active;
    logic                i_Tx_Done;

    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Flush, i_Tx_Active, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
    );

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Flush, i_Tx_Active, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO in front of a UART transmitter. Bytes are accepted at full clock
// rate. A small launch sequencer pops one byte per frame. It waits for the
// transmitter to be idle (not active, not done) before each launch.
module uart_tx_fifo_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_L,
    uart_tx_fifo_feeder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        RECOVER   = 2'd2
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    state_t        state_q;
    logic          tx_dv_q;
    logic [7:0]    tx_byte_q;
    logic          wr_en;
    logic          pop;

    // Accept/pop decisions and next pointer state; flush wins over everything.
    always_comb begin
        wr_en    = bus.i_Wr_DV && !full_q && !bus.i_Flush;
        ovf_d    = bus.i_Wr_DV &&  full_q && !bus.i_Flush;
        pop      = (state_q == IDLE) && !empty_q && !bus.i_Tx_Active &&
                   !bus.i_Tx_Done && !bus.i_Flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.i_Flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = wr_ptr_d - rd_ptr_d;
        full_d  = (count_d == PW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointers and registered status flags.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Byte storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.i_Wr_Byte;
    end

    // Launch sequencer: one pulse per byte, then hold off through done and cleanup.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
                        state_q   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.i_Tx_Done) state_q <= RECOVER;
                end
                RECOVER: begin
                    if (!bus.i_Tx_Done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_Full     = full_q;
    assign bus.o_Empty    = empty_q;
    assign bus.o_Count    = count_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_Tx_DV    = tx_dv_q;
    assign bus.o_Tx_Byte  = tx_byte_q;
endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench for uart_tx_fifo_feeder. A queue-based reference model predicts the
// FIFO status and launch behaviour every cycle. A simple transmitter model
// produces the active and done responses to each launch.
module tb_uart_tx_fifo_feeder;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_fifo_feeder_if #(.DEPTH_LOG2(DL)) ifc();
    uart_tx_fifo_feeder #(.DEPTH_LOG2(DL)) dut (
        .i_Clock (clk),
        .i_Rst_L (rst_n),
        .bus     (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus
    bit         wr_dv, flush;
    logic [7:0] wr_byte;

    // Transmitter model: active for frame_len cycles, then done for 2 cycles
    bit hold_busy, rand_frames;
    int phase, cnt, frame_len;
    bit tx_active, tx_done;

    // Reference model
    logic [7:0] q[$];
    bit         outstanding, done_seen;
    bit         dv_exp, ovf_exp;
    logic [7:0] byte_exp;

    // Observed launches
    logic [7:0] seen[$];
    logic [7:0] exp_list[$];
    int         dv_pulses;

    typedef struct {
        bit         wr;
        logic [7:0] b;
        bit         fl;
        int         cnt;
        bit         full;
        bit         ovf;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tx_advance(input bit dv_in);
        case (phase)
            0: if (dv_in) begin
                   phase = 1;
                   cnt   = rand_frames ? int'($urandom_range(1, 12)) : frame_len;
               end
            1: begin
                   cnt--;
                   if (cnt == 0) begin phase = 2; cnt = 2; end
               end
            default: begin
                   cnt--;
                   if (cnt == 0) phase = 0;
               end
        endcase
        tx_active = hold_busy || (phase == 1);
        tx_done   = (phase == 2);
    endtask

    task automatic model_reset();
        q.delete();
        outstanding = 0;
        done_seen   = 0;
        dv_exp      = 0;
        ovf_exp     = 0;
        byte_exp    = 8'h00;
    endtask

    // One clock: drive inputs, predict, clock, then compare everything.
    task automatic step();
        logic dv_pre;
        bit   full_m, launch;
        ifc.i_Wr_DV     = wr_dv;
        ifc.i_Wr_Byte   = wr_byte;
        ifc.i_Flush     = flush;
        ifc.i_Tx_Active = tx_active;
        ifc.i_Tx_Done   = tx_done;
        dv_pre = ifc.o_Tx_DV;
        full_m = (q.size() == DEPTH);
        launch = !outstanding && (q.size() != 0) && !tx_active && !tx_done && !flush;
        ovf_exp = wr_dv && full_m && !flush;
        dv_exp  = launch;
        if (outstanding) begin
            if (!done_seen) begin
                if (tx_done) done_seen = 1;
            end else if (!tx_done) begin
                outstanding = 0;
            end
        end
        if (flush) begin
            q.delete();
        end else begin
            if (launch) begin
                byte_exp    = q.pop_front();
                outstanding = 1;
                done_seen   = 0;
            end
            if (wr_dv && !full_m) q.push_back(wr_byte);
        end
        @(posedge clk);
        #1;
        tx_advance(dv_pre);
        if (ifc.o_Tx_DV) begin
            seen.push_back(ifc.o_Tx_Byte);
            dv_pulses++;
        end
        chk("count", 32'(ifc.o_Count), 32'(q.size()));
        chk("empty", 32'(ifc.o_Empty), 32'(q.size() == 0));
        chk("full", 32'(ifc.o_Full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(ifc.o_Overflow), 32'(ovf_exp));
        chk("tx_dv", 32'(ifc.o_Tx_DV), 32'(dv_exp));
        chk("tx_byte", 32'(ifc.o_Tx_Byte), 32'(byte_exp));
    endtask

    task automatic drain();
        bit done_ok;
        wr_dv = 0;
        flush = 0;
        for (int i = 0; i < 1000; i++) begin
            done_ok = (q.size() == 0) && !outstanding && (phase == 0) &&
                      !hold_busy && !tx_active && !tx_done;
            if (done_ok) break;
            step();
        end
        chk("drain_timeout", 32'(done_ok), 32'd1);
        repeat (2) step();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        wr_dv = 0;
        flush = 0;
        ifc.i_Wr_DV = 0;
        ifc.i_Flush = 0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(ifc.o_Empty), 32'd1);
        chk("rst_full", 32'(ifc.o_Full), 32'd0);
        chk("rst_count", 32'(ifc.o_Count), 32'd0);
        chk("rst_ovf", 32'(ifc.o_Overflow), 32'd0);
        chk("rst_dv", 32'(ifc.o_Tx_DV), 32'd0);
        chk("rst_byte", 32'(ifc.o_Tx_Byte), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        tx_advance(1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 4, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 8'h66, 1'b0, 4, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b0};

        rst_n = 1'b0;
        wr_dv = 0; flush = 0; wr_byte = 8'h00;
        hold_busy = 0; rand_frames = 0; phase = 0; cnt = 0; frame_len = 4;
        tx_active = 0; tx_done = 0;
        ifc.i_Wr_DV = 0; ifc.i_Wr_Byte = 8'h00; ifc.i_Flush = 0;
        ifc.i_Tx_Active = 0; ifc.i_Tx_Done = 0;
        model_reset();
        dv_pulses = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_empty", 32'(ifc.o_Empty), 32'd1);
        chk("init_count", 32'(ifc.o_Count), 32'd0);
        chk("init_dv", 32'(ifc.o_Tx_DV), 32'd0);
        chk("init_byte", 32'(ifc.o_Tx_Byte), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single byte: launch pulse one cycle after the write lands
        frame_len = 40;
        seen.delete(); dv_pulses = 0;
        wr_dv = 1; wr_byte = 8'hA5;
        step();
        wr_dv = 0;
        chk("a5_no_bypass", 32'(ifc.o_Tx_DV), 32'd0);
        chk("a5_count1", 32'(ifc.o_Count), 32'd1);
        step();
        chk("a5_dv", 32'(ifc.o_Tx_DV), 32'd1);
        chk("a5_byte", 32'(ifc.o_Tx_Byte), 32'hA5);
        chk("a5_empty", 32'(ifc.o_Empty), 32'd1);
        drain();
        chk("a5_pulses", 32'(dv_pulses), 32'd1);

        // Burst of five bytes
        frame_len = 5;
        seen.delete(); dv_pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_dv = 1; wr_byte = 8'(i);
            step();
        end
        drain();
        chk("burst_pulses", 32'(dv_pulses), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("burst_order", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF, 32'(i + 1));

        // Full and overflow with the transmitter held busy (table driven)
        hold_busy = 1; tx_active = 1;
        seen.delete(); dv_pulses = 0;
        for (int i = 0; i < 7; i++) begin
            wr_dv = tbl[i].wr; wr_byte = tbl[i].b; flush = tbl[i].fl;
            step();
            chk("tbl_count", 32'(ifc.o_Count), 32'(tbl[i].cnt));
            chk("tbl_full", 32'(ifc.o_Full), 32'(tbl[i].full));
            chk("tbl_ovf", 32'(ifc.o_Overflow), 32'(tbl[i].ovf));
        end
        hold_busy = 0; tx_active = (phase == 1);
        drain();
        chk("ovf_pulses", 32'(dv_pulses), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("ovf_stream", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF, 32'(tbl[i].b));

        // Simultaneous write and pop at count 2
        hold_busy = 1; tx_active = 1;
        seen.delete(); dv_pulses = 0;
        wr_dv = 1; wr_byte = 8'h77; step();
        wr_byte = 8'h88; step();
        hold_busy = 0; tx_active = (phase == 1); tx_done = (phase == 2);
        wr_byte = 8'h99; step();
        wr_dv = 0;
        chk("simul_count", 32'(ifc.o_Count), 32'd2);
        chk("simul_dv", 32'(ifc.o_Tx_DV), 32'd1);
        chk("simul_byte", 32'(ifc.o_Tx_Byte), 32'h77);
        drain();
        chk("simul_len", 32'(seen.size()), 32'd3);

        // Twenty writes through the FIFO across pointer wrap
        frame_len = 1;
        seen.delete(); exp_list.delete(); dv_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            for (int g = 0; g < 200 && q.size() == DEPTH; g++) begin
                wr_dv = 0; step();
            end
            wr_dv = 1; wr_byte = 8'($urandom);
            exp_list.push_back(wr_byte);
            step();
            wr_dv = 0;
            repeat ($urandom_range(0, 2)) step();
        end
        drain();
        chk("wrap_len", 32'(seen.size()), 32'd20);
        for (int i = 0; i < 20; i++)
            chk("wrap_order", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF, 32'(exp_list[i]));

        // Flush while the first of three bytes is in flight
        frame_len = 20;
        seen.delete(); dv_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            wr_dv = 1; wr_byte = 8'hC0 + 8'(i); step();
        end
        wr_dv = 0; step();
        flush = 1; wr_dv = 1; wr_byte = 8'hEE; step();
        flush = 0; wr_dv = 0;
        chk("flush_count", 32'(ifc.o_Count), 32'd0);
        chk("flush_no_ovf", 32'(ifc.o_Overflow), 32'd0);
        drain();
        chk("flush_pulses", 32'(dv_pulses), 32'd1);
        chk("flush_inflight", (seen.size() > 0) ? 32'(seen[0]) : 32'hFFFF, 32'hC0);

        // Reset with three bytes queued and a frame in flight
        seen.delete(); dv_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            wr_dv = 1; wr_byte = 8'hD0 + 8'(i); step();
        end
        wr_dv = 0; step();
        chk("pre_rst_count", 32'(ifc.o_Count), 32'd3);
        do_reset();
        dv_pulses = 0; seen.delete();
        wr_dv = 1; wr_byte = 8'h5A; step();
        wr_dv = 0;
        drain();
        chk("post_rst_pulses", 32'(dv_pulses), 32'd1);
        chk("post_rst_byte", (seen.size() > 0) ? 32'(seen[0]) : 32'hFFFF, 32'h5A);

        // Randomized traffic against the reference model
        rand_frames = 1;
        for (int i = 0; i < 1500; i++) begin
            wr_dv   = ($urandom_range(0, 1) == 1);
            wr_byte = 8'($urandom);
            flush   = ($urandom_range(0, 79) == 0);
            step();
            if (i == 700) do_reset();
        end
        flush = 0;
        drain();
        rand_frames = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
